// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA framebuffer scanout path.
package vga_pkg;

   localparam int unsigned FIFO_DEPTH_DEF = 8;
   localparam int unsigned ADDR_W_DEF     = 24;
   localparam int unsigned PIX_W          = 8;
   localparam int unsigned WORD_W         = 2 * PIX_W;
   localparam int unsigned FRAME_W        = 20;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DONE
   } vga_state_e;

endpackage

// File: rtl/vga_wordfifo.sv
// Single-clock word FIFO; flush overrides push and pop on the same edge.
module vga_wordfifo
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [WORD_W-1:0] i_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [WORD_W-1:0] o_head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic              do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push && !i_flush) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: fetches RGB332 word pairs over wishbone into a FIFO and
// serves one pixel per gated clock, restarting at the frame base on each i_intv.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [ADDR_W-1:0]  i_base,
   input  logic [FRAME_W-1:0] i_frame_words,
   input  logic               i_intv,
   input  logic               i_pixGate,
   output logic [PIX_W-1:0]   o_pixData,
   output logic               o_underrun,
   input  logic               i_underrun_clr,
   output logic               o_mem_stb,
   output logic [ADDR_W-1:0]  o_mem_addr,
   input  logic               i_mem_ack,
   input  logic [WORD_W-1:0]  i_mem_dat
);

   localparam logic [ADDR_W-1:0]  ADDR_ONE = 1;
   localparam logic [FRAME_W-1:0] WORD_ONE = 1;

   vga_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [FRAME_W-1:0] remaining_q;
   logic               stb_q, stb_d;
   logic               sel_q;
   logic               underrun_q;

   logic              restart, accept, pix_pop;
   logic              fifo_full, fifo_empty;
   logic [WORD_W-1:0] fifo_head;

   // A frame start aborts any open cycle; an ack in that cycle is not taken.
   assign restart = i_enable && i_intv;
   assign accept  = stb_q && i_mem_ack && !restart;
   assign pix_pop = i_pixGate && !fifo_empty && sel_q;

   vga_wordfifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (accept),
      .i_pop   (pix_pop),
      .i_flush (restart),
      .i_data  (i_mem_dat),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_head  (fifo_head)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stb_d   = 1'b0;
      if (restart) begin
         state_d = (i_frame_words == '0) ? S_DONE : S_FETCH;
      end else if (!i_enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (accept && remaining_q == WORD_ONE) state_d = S_DONE;
               // Hold the request until acked, then leave one idle cycle.
               stb_d = stb_q ? !i_mem_ack : (!fifo_full && remaining_q != '0);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_mem_stb  = stb_q && !restart;
      o_mem_addr = addr_q;
      o_underrun = underrun_q;
      o_pixData  = '0;
      if (!fifo_empty) o_pixData = sel_q ? fifo_head[WORD_W-1:PIX_W] : fifo_head[PIX_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         addr_q      <= '0;
         remaining_q <= '0;
         stb_q       <= 1'b0;
         sel_q       <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         stb_q <= stb_d;
         if (restart) begin
            addr_q      <= i_base;
            remaining_q <= i_frame_words;
            sel_q       <= 1'b0;
         end else begin
            if (accept) begin
               addr_q      <= addr_q + ADDR_ONE;
               remaining_q <= remaining_q - WORD_ONE;
            end
            if (i_pixGate && !fifo_empty) sel_q <= !sel_q;
         end
         if (i_pixGate && fifo_empty) underrun_q <= 1'b1;
         else if (i_underrun_clr)     underrun_q <= 1'b0;
      end
   end

endmodule
